// File: rtl/game_sequencer.sv
// Play-flow controller for the breakout game: sequences attract, load, serve, play,
// life-lost, level-clear and game-over, and owns lives, score, level and ball speed.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int NUM_BRICKS   = 18,
  parameter int BRICK_PTS    = 10,
  parameter int SCORE_W      = 16,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SPEED_INIT   = 5,
  parameter int SPEED_MAX    = 9
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame,
  input  logic                              btn1,
  input  logic                              btn2,
  input  logic                              brick_hit,
  input  logic                              ball_lost,
  input  logic [$clog2(NUM_BRICKS+1)-1:0]   bricks_left,
  output logic [2:0]                        state,
  output logic                              run,
  output logic                              load_level,
  output logic                              serve,
  output logic [$clog2(LIVES+1)-1:0]        lives,
  output logic [SCORE_W-1:0]                score,
  output logic [3:0]                        level,
  output logic [9:0]                        ball_speed
);

  localparam int LW   = $clog2(LIVES + 1);
  localparam int TMAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SERVE = 3'd2,
    S_PLAY  = 3'd3,
    S_LOST  = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_run, w_run_nxt;
  logic               r_load, w_load_nxt;
  logic               r_serve, w_serve_nxt;
  logic [LW-1:0]      r_lives, w_lives_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [3:0]         r_level, w_level_nxt;
  logic [9:0]         r_speed, w_speed_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic               r_btn_prev;

  logic               w_press;
  logic [TW-1:0]      w_timer_dec;
  logic [SCORE_W:0]   w_score_sum;
  logic [SCORE_W-1:0] w_score_sat;

  assign w_press     = (btn1 | btn2) & ~r_btn_prev;
  assign w_timer_dec = (r_timer == '0) ? '0 : r_timer - TW'(1);
  assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(BRICK_PTS);
  assign w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

  // NOTE: every next-state signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = 1'b0;
    w_load_nxt  = 1'b0;
    w_serve_nxt = 1'b0;
    w_lives_nxt = r_lives;
    w_score_nxt = r_score;
    w_level_nxt = r_level;
    w_speed_nxt = r_speed;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: if (w_press) begin
        w_state_nxt = S_LOAD;
        w_load_nxt  = 1'b1;
        w_lives_nxt = LW'(LIVES);
        w_score_nxt = '0;
        w_level_nxt = '0;
        w_speed_nxt = 10'(SPEED_INIT);
      end
      S_LOAD: begin
        w_state_nxt = S_SERVE;
        w_serve_nxt = 1'b1;
        w_timer_nxt = TW'(SERVE_FRAMES);
      end
      S_SERVE: if (frame) begin
        w_timer_nxt = w_timer_dec;
        if (r_timer <= TW'(1)) begin
          w_state_nxt = S_PLAY;
          w_run_nxt   = 1'b1;
        end
      end
      S_PLAY: begin
        w_run_nxt = 1'b1;
        if (brick_hit) w_score_nxt = w_score_sat;
        // Clearing the level outranks losing the ball on the same cycle.
        if (bricks_left == '0) begin
          w_state_nxt = S_CLEAR;
          w_run_nxt   = 1'b0;
          w_level_nxt = (r_level == 4'd15) ? r_level : r_level + 4'd1;
          w_speed_nxt = (r_speed >= 10'(SPEED_MAX)) ? r_speed : r_speed + 10'd1;
        end else if (ball_lost) begin
          w_run_nxt = 1'b0;
          if (r_lives <= LW'(1)) begin
            w_lives_nxt = '0;
            w_state_nxt = S_OVER;
            w_timer_nxt = TW'(OVER_FRAMES);
          end else begin
            w_lives_nxt = r_lives - LW'(1);
            w_state_nxt = S_LOST;
            w_timer_nxt = TW'(SERVE_FRAMES);
          end
        end
      end
      S_LOST: if (frame) begin
        w_timer_nxt = w_timer_dec;
        if (r_timer <= TW'(1)) begin
          w_state_nxt = S_SERVE;
          w_serve_nxt = 1'b1;
          w_timer_nxt = TW'(SERVE_FRAMES);
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_LOAD;
        w_load_nxt  = 1'b1;
      end
      S_OVER: begin
        if (frame) w_timer_nxt = w_timer_dec;
        if (w_press && r_timer == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_load     <= 1'b0;
      r_serve    <= 1'b0;
      r_lives    <= LW'(LIVES);
      r_score    <= '0;
      r_level    <= '0;
      r_speed    <= 10'(SPEED_INIT);
      r_timer    <= '0;
      r_btn_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_load     <= w_load_nxt;
      r_serve    <= w_serve_nxt;
      r_lives    <= w_lives_nxt;
      r_score    <= w_score_nxt;
      r_level    <= w_level_nxt;
      r_speed    <= w_speed_nxt;
      r_timer    <= w_timer_nxt;
      r_btn_prev <= btn1 | btn2;
    end
  end

  assign state      = r_state;
  assign run        = r_run;
  assign load_level = r_load;
  assign serve      = r_serve;
  assign lives      = r_lives;
  assign score      = r_score;
  assign level      = r_level;
  assign ball_speed = r_speed;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed play-flow scenarios plus random
// stimulus, all compared every cycle against a behavioural game model.
module tb_game_sequencer;

  localparam int LIVES = 3, BRICK_PTS = 10, SERVE_FRAMES = 60, OVER_FRAMES = 180;
  localparam int SPEED_INIT = 5, SPEED_MAX = 9, SCORE_MAX = 65535, NUM_BRICKS = 18;
  localparam int IDLE = 0, LOAD = 1, SERVE = 2, PLAY = 3, LOST = 4, CLEAR = 5, OVER = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame = 1'b0, btn1 = 1'b0, btn2 = 1'b0, brick_hit = 1'b0, ball_lost = 1'b0;
  logic [4:0] bricks_left = 5'd18;
  logic [2:0] state;
  logic       run, load_level, serve;
  logic [1:0] lives;
  logic [15:0] score;
  logic [3:0] level;
  logic [9:0] ball_speed;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the game rules
  int m_phase, m_lives, m_score, m_level, m_speed, m_wait;
  bit m_prev, m_load, m_serve;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .btn1(btn1), .btn2(btn2),
    .brick_hit(brick_hit), .ball_lost(ball_lost), .bricks_left(bricks_left),
    .state(state), .run(run), .load_level(load_level), .serve(serve),
    .lives(lives), .score(score), .level(level), .ball_speed(ball_speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = IDLE; m_lives = LIVES; m_score = 0; m_level = 0; m_speed = SPEED_INIT;
    m_wait = 0; m_prev = 0; m_load = 0; m_serve = 0;
  endtask

  task automatic model_step();
    bit press;
    press   = (btn1 || btn2) && !m_prev;
    m_prev  = btn1 || btn2;
    m_load  = 0;
    m_serve = 0;
    case (m_phase)
      IDLE: if (press) begin
        m_phase = LOAD; m_load = 1; m_lives = LIVES; m_score = 0; m_level = 0;
        m_speed = SPEED_INIT;
      end
      LOAD: begin m_phase = SERVE; m_serve = 1; m_wait = SERVE_FRAMES; end
      SERVE: if (frame) begin
        if (m_wait <= 1) m_phase = PLAY;
        m_wait = (m_wait > 0) ? m_wait - 1 : 0;
      end
      PLAY: begin
        if (brick_hit) m_score = (m_score + BRICK_PTS > SCORE_MAX) ? SCORE_MAX : m_score + BRICK_PTS;
        if (bricks_left == 0) begin
          m_phase = CLEAR;
          m_level = (m_level < 15) ? m_level + 1 : 15;
          m_speed = (m_speed < SPEED_MAX) ? m_speed + 1 : SPEED_MAX;
        end else if (ball_lost) begin
          m_lives = m_lives - 1;
          m_phase = (m_lives == 0) ? OVER : LOST;
          m_wait  = (m_lives == 0) ? OVER_FRAMES : SERVE_FRAMES;
        end
      end
      LOST: if (frame) begin
        if (m_wait <= 1) begin
          m_phase = SERVE; m_serve = 1; m_wait = SERVE_FRAMES;
        end else m_wait = m_wait - 1;
      end
      CLEAR: begin m_phase = LOAD; m_load = 1; end
      OVER: begin
        if (press && m_wait == 0) m_phase = IDLE;
        else if (frame && m_wait > 0) m_wait = m_wait - 1;
      end
      default: m_phase = IDLE;
    endcase
  endtask

  task automatic check_all();
    check("state", state, m_phase);
    check("run", run, (m_phase == PLAY) ? 1 : 0);
    check("load_level", load_level, m_load);
    check("serve", serve, m_serve);
    check("lives", lives, m_lives);
    check("score", score, m_score);
    check("level", level, m_level);
    check("ball_speed", ball_speed, m_speed);
  endtask

  // Inputs change at negedge; the DUT and model both see them at the next posedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic frame_pulse();
    frame = 1'b1; step(); frame = 1'b0;
  endtask

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) begin frame_pulse(); step(); end
  endtask

  task automatic press_btn();
    btn1 = 1'b1; step(); btn1 = 1'b0; step();
  endtask

  task automatic serve_to_play();
    do_frames(SERVE_FRAMES - 1);
    check("serve_hold", state, SERVE);
    frame_pulse();
    check("play_entry", state, PLAY);
    check("play_run", run, 1);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Start game
    btn1 = 1'b1; step(); btn1 = 1'b0;
    check("start_load", state, LOAD);
    check("start_load_pulse", load_level, 1);
    step();
    check("start_serve", state, SERVE);
    check("start_serve_pulse", serve, 1);
    check("start_lives", lives, 3);
    serve_to_play();

    // Score and level clear
    for (int i = 0; i < 3; i++) begin brick_hit = 1'b1; step(); brick_hit = 1'b0; step(); end
    check("three_hits", score, 30);
    bricks_left = 5'd0; step(); bricks_left = 5'd18;
    check("clear_state", state, CLEAR);
    check("clear_level", level, 1);
    check("clear_speed", ball_speed, 6);
    step();
    check("reload", load_level, 1);
    step();
    serve_to_play();

    // Lose all lives
    for (int k = 0; k < 3; k++) begin
      ball_lost = 1'b1; step(); ball_lost = 1'b0;
      check("lost_lives", lives, 2 - k);
      if (k < 2) begin
        check("lost_state", state, LOST);
        do_frames(SERVE_FRAMES - 1);
        frame_pulse();
        check("lost_to_serve", state, SERVE);
        check("lost_serve_pulse", serve, 1);
        check("lost_no_load", load_level, 0);
        serve_to_play();
      end
    end
    check("over_state", state, OVER);
    do_frames(OVER_FRAMES - 1);
    press_btn();
    check("over_early_press", state, OVER);
    do_frames(1);
    btn2 = 1'b1; step(); btn2 = 1'b0;
    check("over_to_idle", state, IDLE);
    check("score_held", score, 30);
    step();

    // Simultaneous hit, loss and clear
    press_btn();
    serve_to_play();
    brick_hit = 1'b1; ball_lost = 1'b1; bricks_left = 5'd0; step();
    brick_hit = 1'b0; ball_lost = 1'b0; bricks_left = 5'd18;
    check("combo_score", score, 10);
    check("combo_state", state, CLEAR);
    check("combo_lives", lives, 3);
    step(); step();
    serve_to_play();

    // Score saturation
    brick_hit = 1'b1;
    for (int i = 0; i < 6552; i++) step();
    check("score_65530", score, 65530);
    step();
    check("score_sat", score, 65535);
    step();
    check("score_sat_hold", score, 65535);
    brick_hit = 1'b0;

    // Asynchronous reset mid-play
    check("pre_reset_play", state, PLAY);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Random play against the model
    for (int i = 0; i < 8000; i++) begin
      frame       = ($urandom_range(0, 3) == 0);
      btn1        = ($urandom_range(0, 7) == 0);
      btn2        = ($urandom_range(0, 15) == 0);
      brick_hit   = ($urandom_range(0, 3) == 0);
      ball_lost   = ($urandom_range(0, 15) == 0);
      bricks_left = ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, NUM_BRICKS));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
